// File: rtl/axi4_sram_rd_slave_if.sv
// AXI4 read-address and read-data channel bundle shared by the SRAM read slave and its master.
interface axi4_sram_rd_slave_if #(
  parameter int A = 32,
  parameter int N = 8,
  parameter int I = 1
);
  logic [I-1:0]   arid;
  logic [A-1:0]   araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           arvalid;
  logic           arready;
  logic [I-1:0]   rid;
  logic [8*N-1:0] rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_sram_rd_slave.sv
// AXI4 read slave over a 1-cycle-latency synchronous SRAM with a 2-entry credit-managed R FIFO.
// WRAP bursts are served only when AXI4_SRAM_RD_WRAP_EN is defined; otherwise they return SLVERR.
module axi4_sram_rd_slave #(
  parameter int A = 32,
  parameter int N = 8,
  parameter int I = 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axi4_sram_rd_slave_if.slave    bus,
  output logic [A-$clog2(N)-1:0] ram_addr,
  output logic                   ram_rd_en,
  input  logic [8*N-1:0]         ram_rdata
);
  localparam int S  = $clog2(N);
  localparam int DW = 8 * N;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  function automatic logic [A-1:0] size_mask(input logic [2:0] size);
    return (A'(1) << size) - A'(1);
  endfunction

  function automatic logic [A-1:0] wrap_mask(input logic [7:0] len, input logic [2:0] size);
    return ((A'(len) + A'(1)) << size) - A'(1);
  endfunction

  function automatic logic [A-1:0] next_addr(input logic [A-1:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst, input logic [7:0] len);
    logic [A-1:0] step;
    logic [A-1:0] wm;
    logic [A-1:0] nxt;
    step = A'(1) << size;
    wm   = wrap_mask(len, size);
    case (burst)
      2'b01:   nxt = (addr & ~size_mask(size)) + step;
      2'b10:   nxt = (addr & ~wm) | ((addr + step) & wm);
      default: nxt = addr;
    endcase
    return nxt;
  endfunction

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic wrap_ok);
    return (int'(size) > S) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok);
  endfunction

  state_t         state_q, state_d;
  logic           arready_q;
  logic [7:0]     beat_cnt;
  logic [I-1:0]   id_q;
  logic [A-1:0]   addr_q;
  logic [7:0]     len_q;
  logic [2:0]     size_q;
  logic [1:0]     burst_q;
  logic           err_q;
  logic           vld_p0;
  logic [I-1:0]   id_p0;
  logic           last_p0;
  logic           err_p0;
  logic [I-1:0]   fifo_id   [2];
  logic [DW-1:0]  fifo_data [2];
  logic [1:0]     fifo_resp [2];
  logic           fifo_last [2];
  logic           wr_ptr, rd_ptr;
  logic [1:0]     count;
  logic           ar_hs, pop, issue, last_beat, rvalid, wrap_ok;
  logic [2:0]     credit;

`ifdef AXI4_SRAM_RD_WRAP_EN
  always_comb begin
    wrap_ok = (bus.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}) &&
              ((bus.araddr & size_mask(bus.arsize)) == '0);
  end
`else
  assign wrap_ok = 1'b0;
`endif

  assign ar_hs     = bus.arvalid && arready_q;
  assign rvalid    = (count != 2'd0);
  assign pop       = rvalid && bus.rready;
  // Slots already committed (queued + in the SRAM pipe) less the one leaving this cycle.
  assign credit    = {1'b0, count} + {2'b00, vld_p0} - {2'b00, pop};
  assign last_beat = (beat_cnt == len_q);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ar_hs) state_d = BURST;
      end
      BURST: begin
        issue = (credit < 3'd2);
        if (issue && last_beat) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      beat_cnt  <= 8'd0;
      vld_p0    <= 1'b0;
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= (state_d == IDLE);
      if (ar_hs)
        beat_cnt <= 8'd0;
      else if (issue)
        beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
      vld_p0 <= issue;
      if (vld_p0) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, vld_p0} - {1'b0, pop};
    end
  end

  // Stage p0: beat issued to SRAM, metadata waits for ram_rdata.
  always_ff @(posedge aclk) begin
    if (ar_hs) begin
      id_q    <= bus.arid;
      addr_q  <= bus.araddr;
      len_q   <= bus.arlen;
      size_q  <= bus.arsize;
      burst_q <= bus.arburst;
      err_q   <= burst_err(bus.arsize, bus.arburst, wrap_ok);
    end else if (issue) begin
      addr_q  <= next_addr(addr_q, size_q, burst_q, len_q);
    end
    if (issue) begin
      id_p0   <= id_q;
      last_p0 <= last_beat;
      err_p0  <= err_q;
    end
    // Stage p1: SRAM word (or zeroed error slot) lands in the FIFO.
    if (vld_p0) begin
      fifo_id[wr_ptr]   <= id_p0;
      fifo_data[wr_ptr] <= err_p0 ? '0 : ram_rdata;
      fifo_resp[wr_ptr] <= err_p0 ? 2'b10 : 2'b00;
      fifo_last[wr_ptr] <= last_p0;
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid;
  assign bus.rid     = rvalid ? fifo_id[rd_ptr]   : '0;
  assign bus.rdata   = rvalid ? fifo_data[rd_ptr] : '0;
  assign bus.rresp   = rvalid ? fifo_resp[rd_ptr] : 2'b00;
  assign bus.rlast   = rvalid ? fifo_last[rd_ptr] : 1'b0;
  assign ram_rd_en   = issue && !err_q;
  assign ram_addr    = (state_q == BURST) ? addr_q[A-1:S] : '0;
endmodule

// File: tb/tb_axi4_sram_rd_slave.sv
// Scoreboard bench for axi4_sram_rd_slave: directed AR bursts, expected beats queued at issue time.
module tb_axi4_sram_rd_slave;
  localparam int A  = 32;
  localparam int N  = 8;
  localparam int I  = 1;
  localparam int S  = 3;
  localparam int DW = 64;

  typedef struct packed {
    logic [I-1:0]  id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [A-S-1:0] ram_addr;
  logic           ram_rd_en;
  logic [DW-1:0]  ram_rdata = '1;

  axi4_sram_rd_slave_if #(.A(A), .N(N), .I(I)) bus();

  axi4_sram_rd_slave #(.A(A), .N(N), .I(I)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_rd_en (ram_rd_en),
    .ram_rdata (ram_rdata)
  );

  always #5 aclk = ~aclk;

  beat_t          exp_q[$];
  logic [A-S-1:0] ram_q[$];
  int             n_cmp = 0;
  int             n_fail = 0;
  int             beats_seen = 0;
  int             occ = 0;
  int             rk = 0;
  logic           stall_mode = 1'b0;
  logic [3:0]     rpat = 4'b1001;
  logic           hold_chk = 1'b0;
  logic [67:0]    held = '0;

  function automatic logic [DW-1:0] word_of(input logic [A-S-1:0] wa);
    return {32'hC0DE_0000 ^ 32'(wa), ~32'(wa)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: actual=event required=none", name);
  endtask

  task automatic exp_beat(input logic [I-1:0] id, input logic [A-S-1:0] wa,
                          input logic err, input logic last);
    beat_t b;
    b.id   = id;
    b.data = err ? '0 : word_of(wa);
    b.resp = err ? 2'b10 : 2'b00;
    b.last = last;
    exp_q.push_back(b);
    if (!err) ram_q.push_back(wa);
  endtask

  task automatic send_ar(input logic [I-1:0] id, input logic [A-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t;
    t = 0;
    bus.arid    = id;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arsize  = size;
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    @(negedge aclk);
    while (!bus.arready && t < 50) begin
      @(negedge aclk);
      t++;
    end
    check("ar_accept", 128'(bus.arready), 128'(1));
    @(posedge aclk);
    #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge aclk);
      t++;
    end
    check({name, "_drain"}, 128'(exp_q.size()), 128'(0));
    @(posedge aclk);
    #1;
  endtask

  // SRAM model: 1-cycle read latency, holds last word when not read.
  always @(posedge aclk) begin
    if (ram_rd_en) ram_rdata <= word_of(ram_addr);
  end

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) occ <= 0;
    else occ <= occ + int'(ram_rd_en) - int'(bus.rvalid && bus.rready);
  end

  initial begin
    bus.rready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      bus.rready = stall_mode ? rpat[rk % 4] : 1'b1;
      rk++;
    end
  end

  always @(negedge aclk) begin
    if (!aresetn) begin
      hold_chk <= 1'b0;
    end else begin
      if (hold_chk) begin
        check("stall_rvalid", 128'(bus.rvalid), 128'(1));
        check("stall_hold", 128'({bus.rid, bus.rdata, bus.rresp, bus.rlast}), 128'(held));
      end
      hold_chk <= bus.rvalid && !bus.rready;
      held     <= {bus.rid, bus.rdata, bus.rresp, bus.rlast};
      if (bus.rvalid && bus.rready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("rid",   128'(bus.rid),   128'(e.id));
          check("rdata", 128'(bus.rdata), 128'(e.data));
          check("rresp", 128'(bus.rresp), 128'(e.resp));
          check("rlast", 128'(bus.rlast), 128'(e.last));
        end
        beats_seen <= beats_seen + 1;
      end
      if (ram_rd_en) begin
        if (ram_q.size() == 0) begin
          fail_now("unexpected_ram_read");
        end else begin
          logic [A-S-1:0] ea;
          ea = ram_q.pop_front();
          check("ram_addr", 128'(ram_addr), 128'(ea));
        end
        check("credit_le2", 128'((occ + 1 - int'(bus.rvalid && bus.rready)) <= 2), 128'(1));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int nv;
    int target;
    int t;
    bus.arvalid = 1'b0;
    bus.arid    = '0;
    bus.araddr  = '0;
    bus.arlen   = '0;
    bus.arsize  = '0;
    bus.arburst = '0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_arready", 128'(bus.arready), 128'(0));
    check("rst_rvalid",  128'(bus.rvalid),  128'(0));
    check("rst_rlast",   128'(bus.rlast),   128'(0));
    check("rst_rd_en",   128'(ram_rd_en),   128'(0));
    check("rst_outs",    128'({bus.rid, bus.rdata, bus.rresp}), 128'(0));
    check("rst_ram_addr", 128'(ram_addr), 128'(0));
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("arready_after_reset", 128'(bus.arready), 128'(1));

    // INCR 0x100, 4 x 8 bytes
    for (int i = 0; i < 4; i++) exp_beat(1'b1, 29'h20 + 29'(i), 1'b0, i == 3);
    send_ar(1'b1, 32'h100, 8'd3, 3'd3, 2'b01);
    lat = 0;
    do begin
      @(posedge aclk);
      #1;
      lat++;
    end while (!bus.rvalid && lat < 10);
    check("latency", 128'(lat), 128'(2));
    nv = 0;
    repeat (4) begin
      @(negedge aclk);
      if (bus.rvalid) nv++;
    end
    check("back_to_back", 128'(nv), 128'(4));
    wait_drain("incr");

    // Same burst under rready backpressure
    stall_mode = 1'b1;
    for (int i = 0; i < 4; i++) exp_beat(1'b0, 29'h20 + 29'(i), 1'b0, i == 3);
    send_ar(1'b0, 32'h100, 8'd3, 3'd3, 2'b01);
    wait_drain("incr_stall");
    stall_mode = 1'b0;

    // FIXED
    for (int i = 0; i < 3; i++) exp_beat(1'b1, 29'h09, 1'b0, i == 2);
    send_ar(1'b1, 32'h48, 8'd2, 3'd3, 2'b00);
    wait_drain("fixed");

    // Oversized beat -> SLVERR, no RAM access
    exp_beat(1'b0, '0, 1'b1, 1'b0);
    exp_beat(1'b0, '0, 1'b1, 1'b1);
    send_ar(1'b0, 32'h100, 8'd1, 3'd4, 2'b01);
    wait_drain("oversize");

    // WRAP
`ifdef AXI4_SRAM_RD_WRAP_EN
    exp_beat(1'b1, 29'h03, 1'b0, 1'b0);
    exp_beat(1'b1, 29'h00, 1'b0, 1'b0);
    exp_beat(1'b1, 29'h01, 1'b0, 1'b0);
    exp_beat(1'b1, 29'h02, 1'b0, 1'b1);
`else
    for (int i = 0; i < 4; i++) exp_beat(1'b1, '0, 1'b1, i == 3);
`endif
    send_ar(1'b1, 32'h18, 8'd3, 3'd3, 2'b10);
    wait_drain("wrap");

    // Unaligned INCR with narrow beats
    exp_beat(1'b1, 29'h20, 1'b0, 1'b0);
    exp_beat(1'b1, 29'h21, 1'b0, 1'b0);
    exp_beat(1'b1, 29'h21, 1'b0, 1'b1);
    send_ar(1'b1, 32'h104, 8'd2, 3'd2, 2'b01);
    wait_drain("incr_narrow");

    // Reserved burst type, single beat
    exp_beat(1'b0, '0, 1'b1, 1'b1);
    send_ar(1'b0, 32'h40, 8'd0, 3'd3, 2'b11);
    wait_drain("reserved");

    // Back-to-back ARs, then reset during the second burst
    target = beats_seen + 2;
    exp_beat(1'b0, 29'h40, 1'b0, 1'b0);
    exp_beat(1'b0, 29'h41, 1'b0, 1'b1);
    exp_beat(1'b1, 29'h60, 1'b0, 1'b1);
    send_ar(1'b0, 32'h200, 8'd1, 3'd3, 2'b01);
    send_ar(1'b1, 32'h300, 8'd0, 3'd3, 2'b01);
    t = 0;
    while (beats_seen < target && t < 50) begin
      @(negedge aclk);
      t++;
    end
    check("first_burst_done", 128'(beats_seen >= target), 128'(1));
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    exp_q.delete();
    ram_q.delete();
    #2;
    check("midrst_rvalid",  128'(bus.rvalid),  128'(0));
    check("midrst_arready", 128'(bus.arready), 128'(0));
    check("midrst_rd_en",   128'(ram_rd_en),   128'(0));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("post_rst_arready", 128'(bus.arready), 128'(1));
    check("post_rst_rvalid",  128'(bus.rvalid),  128'(0));

    // Normal operation after reset
    exp_beat(1'b1, 29'h01, 1'b0, 1'b1);
    send_ar(1'b1, 32'h8, 8'd0, 3'd3, 2'b01);
    wait_drain("post_rst");

    repeat (3) @(posedge aclk);
    #1;
    check("ram_q_empty", 128'(ram_q.size()), 128'(0));
    check("final_rvalid", 128'(bus.rvalid), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4_sram_rd_slave.md
Name: axi4_sram_rd_slave

Overview:
- AXI4 read-channel slave that sits directly downstream of the team's AXI4 interface bundle.
- Consumes the AR channel and produces R beats by reading a synchronous single-port SRAM with 1-cycle read latency.
- A 2-entry output FIFO and a pop-aware credit scheme sustain 1 beat/cycle while honouring rready backpressure.
- The write channels are out of scope and handled by a sibling block.

Parameters:
- A, 32, address bus width in bits
- N, 8, data bus width in bytes; power of 2, 1..128
- I, 1, ID width

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- arid  in  I  read ID
- araddr  in  A  byte start address
- arlen  in  8  beats minus 1
- arsize  in  3  log2 bytes per beat
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  I  echoed arid
- rdata  out  8*N  read data
- rresp  out  2  00 OKAY, 10 SLVERR
- rlast  out  1  final beat of burst
- rvalid  out  1  R valid
- rready  in  1  R ready
- ram_addr  out  A-log2(N)  SRAM word address
- ram_rd_en  out  1  SRAM read strobe
- ram_rdata  in  8*N  SRAM data, valid the cycle after ram_rd_en

Behaviour:
- Clocking and reset: single clock aclk; aresetn asynchronous assert, active-low, synchronous deassert by the system.
- Reset values:
  - arready=0, rvalid=0, rlast=0, ram_rd_en=0
  - rid, rdata, rresp, ram_addr = 0
  - FIFO empty, beat counter 0, FSM IDLE
  - First cycle after reset: arready=1.
- FSM IDLE:
  - arready=1.
  - On arvalid&&arready, latch id, addr, len, size, burst, error flag; go to BURST. arready=0 from the next cycle.
- FSM BURST:
  - arready=0.
  - Issue one beat per cycle while (fifo_count + inflight - pop) < 2, where pop = rvalid&&rready.
  - On issuing the last beat (beat_cnt==len), return to IDLE. A new AR may be accepted while earlier beats still drain.
- Latency:
  - AR handshake at edge k; ram_rd_en high in cycle k+1; ram_rdata captured into FIFO at edge k+2.
  - rvalid high in cycle k+2 onward, i.e. 2 cycles after handshake. Sustained 1 beat/cycle with rready=1.
- FIFO entry contents: {id, data, resp, last}. Ordering strictly preserved across bursts.
- Address generation:
  - ram_addr = addr >> log2(N). rdata always carries the full word; the master selects lanes.
  - INCR: beat 0 uses araddr. Subsequent beats use (aligned_addr + n<<size), aligned_addr = araddr with low size bits cleared. Address wraps modulo 2^A; no 4KB check.
  - FIXED: every beat uses araddr.
- Error bursts:
  - Triggered by arsize > log2(N), arburst=11, or WRAP when the feature is off.
  - Every beat still delivered, arlen+1 beats, rlast on the final one.
  - rresp=10, rdata=0, ram_rd_en held low for those beats; the slot still occupies pipeline/FIFO credit.
- rlast=1 exactly on beat arlen; arlen=0 gives a single beat with rlast=1.
- While rvalid&&!rready, rid/rdata/rresp/rlast must hold stable.
- Simultaneous FIFO push and pop when count=2 cannot occur; the credit rule forbids it. Push and pop at count=1 keeps count=1.
- Reset mid-burst: all state cleared immediately, outputs to reset values, in-flight beats discarded.

Optional Feature:
- Macro: AXI4_SRAM_RD_WRAP_EN.
- Defined:
  - WRAP bursts supported.
  - arlen must be 1, 3, 7 or 15, else the burst is treated as an error burst.
  - Wrap boundary = (arlen+1)<<arsize; start address must be size-aligned, else error burst.
  - Address = base + ((offset + n<<size) mod boundary).
- Undefined: arburst=10 is an error burst (SLVERR on all beats, no RAM reads).

Test Plan:
- INCR, N=8, araddr=0x100, arlen=3, arsize=3, rready=1 -> ram_addr 0x20..0x23 on consecutive cycles; 4 beats back-to-back, rlast on 4th, rresp=00, rid=arid.
- Same burst with rready toggling 1,0,0,1,… -> no beat lost or duplicated; outputs stable while stalled; ram_rd_en never pushes FIFO past 2 entries.
- FIXED, araddr=0x48, arlen=2 -> ram_addr=0x09 three times; 3 beats, last flagged.
- arsize=4 with N=8 and arlen=1 -> 2 beats rresp=10, rdata=0, ram_rd_en never asserted.
- WRAP, araddr=0x18, arlen=3, arsize=3: with macro -> ram_addr 0x03,0x00,0x01,0x02; without macro -> 4 SLVERR beats.
- Back-to-back ARs (id 0 len 1, id 1 len 0), then aresetn pulsed low mid second burst -> ordered beats before reset; after reset rvalid=0, arready=1 next cycle.
